// File: rtl/clk_gen_ctrl.sv
// clk_gen_ctrl: NCH programmable clock dividers whose enable and ratio changes land on period boundaries
module clk_gen_ctrl #(
  parameter int NCH = 4,
  parameter int DW = 16,
  parameter int DEF_DIV = 4,
  localparam int CW = NCH > 1 ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cfg_we,
  input  logic [CW-1:0]  cfg_ch,
  input  logic [DW-1:0]  cfg_div,
  output logic           cfg_err,
  input  logic [NCH-1:0] en_req,
  output logic [NCH-1:0] clk_out,
  output logic [NCH-1:0] tick,
  output logic [NCH-1:0] running
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  logic wr_ok;
  assign wr_ok = cfg_we && cfg_div >= DW'(2) && {1'b0, cfg_ch} < (CW+1)'(NCH);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cfg_err <= 1'b0;
    else cfg_err <= cfg_we && !wr_ok;
  for (genvar c = 0; c < NCH; c++) begin : g_ch
    state_t st, st_n;
    logic [DW-1:0] cnt, cnt_n, div_cur, div_n, div_pend;
    logic pv, wrap, wr, co, tk, rn;
    always_comb begin
      wr = wr_ok && cfg_ch == CW'(c);
      wrap = st != IDLE && cnt == div_cur - 1'b1;
      st_n = (st == IDLE || wrap) ? (en_req[c] ? RUN : IDLE) : (en_req[c] ? st : DRAIN);
      cnt_n = (st == IDLE || wrap) ? '0 : cnt + 1'b1;
      div_n = (wrap && pv) ? div_pend : (wr && st == IDLE) ? cfg_div : div_cur;
    end
    // outputs are registered from next-state values so the first period appears one cycle after en_req
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        st <= IDLE;
        cnt <= '0;
        div_cur <= DW'(DEF_DIV);
        div_pend <= DW'(DEF_DIV);
        pv <= 1'b0;
        co <= 1'b0;
        tk <= 1'b0;
        rn <= 1'b0;
      end else begin
        st <= st_n;
        cnt <= cnt_n;
        div_cur <= div_n;
        if (wr && st != IDLE) begin
          div_pend <= cfg_div;
          pv <= 1'b1;
        end else if (wrap) pv <= 1'b0;
        co <= st_n != IDLE && cnt_n < (div_n >> 1);
        tk <= st_n != IDLE && cnt_n == '0;
        rn <= st_n != IDLE;
      end
    assign clk_out[c] = co;
    assign tick[c] = tk;
    assign running[c] = rn;
  end
endmodule
